// File: rtl/bitstream_decoder.sv
// rtl/bitstream_decoder.sv - stochastic bitstream to binary window decoder
//
// Purpose: counts the ones in a window of 2**WINDOW_LOG2 enabled samples and
// presents the decoded value on a valid/ready output port.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears all state
//   start      begin a new window (IDLE, or HOLD together with out_ready)
//   bit_in     stochastic bitstream sample
//   bit_en     bit_in is a valid sample this cycle
//   out_ready  consumer accepts out_value
//   out_value  decoded result: ones count, or 2*ones - N when BIPOLAR=1
//   out_valid  out_value is valid and held stable
//   busy       a window is being accumulated

module bitstream_decoder #(
    parameter int WINDOW_LOG2 = 8,
    parameter bit BIPOLAR     = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   bit_in,
    input  logic                   bit_en,
    input  logic                   out_ready,
    output logic [WINDOW_LOG2+1:0] out_value,
    output logic                   out_valid,
    output logic                   busy
);

    localparam int                     N     = 1 << WINDOW_LOG2;
    localparam logic [WINDOW_LOG2+1:0] N_VAL = (WINDOW_LOG2+2)'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WINDOW_LOG2-1:0] sample_cnt;
    logic [WINDOW_LOG2:0]   ones_cnt;
    logic [WINDOW_LOG2:0]   final_cnt;
    logic [WINDOW_LOG2+1:0] result;
    logic                   last_sample;
    logic                   restart;
    logic                   clear_cnt;

    // Count including the current sample, so the last sample's bit is part of the result.
    assign final_cnt   = ones_cnt + (WINDOW_LOG2+1)'(bit_in);
    assign last_sample = (state == COUNT) && bit_en && (sample_cnt == {WINDOW_LOG2{1'b1}});
    assign restart     = (state == HOLD) && out_ready && start;
    // Clearing on a HOLD restart means the next window starts with no bubble cycle.
    assign clear_cnt   = (state == IDLE) || restart;

    always_comb begin
        result = {1'b0, final_cnt};
        if (BIPOLAR) begin
            // 2*c - N in two's complement; range -N..+N fits WINDOW_LOG2+2 bits.
            result = {final_cnt, 1'b0} - N_VAL;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (last_sample) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = start ? COUNT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if (clear_cnt) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
        end else if ((state == COUNT) && bit_en) begin
            sample_cnt <= sample_cnt + 1'b1;
            ones_cnt   <= final_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_value <= '0;
        end else if (last_sample) begin
            out_value <= result;
        end
    end

    // Outputs decode the registered state only: no input-to-output path.
    assign out_valid = (state == HOLD);
    assign busy      = (state == COUNT);

endmodule
